// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM state encoding,
// default timing parameters and the hold/stagger counter width.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_HOLD_CYC    = 8;
  localparam int DEF_STAGGER_CYC = 2;
  localparam int CNT_W           = $clog2(256);

endpackage

// File: rtl/reset_seq_if.sv
// Retrigger request/acknowledge and reset-output bundle for reset_seq.
// trig_req is a level held by the master until it sees the one-cycle trig_ack
// pulse; ch_mask is sampled on the accepting edge and the master must drop or
// change the request in the cycle it observes trig_ack.
interface reset_seq_if
  import reset_seq_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH
);
  logic              trig_req;
  logic [NUM_CH-1:0] ch_mask;
  logic              trig_ack;
  logic [NUM_CH-1:0] rst_out;
  logic              busy;
  logic              done;

  modport master (
    output trig_req, ch_mask,
    input  trig_ack, rst_out, busy, done
  );

  modport slave (
    input  trig_req, ch_mask,
    output trig_ack, rst_out, busy, done
  );
endinterface

// File: rtl/reset_seq_cnt.sv
// Non-wrapping down-counter shared by the hold and stagger phases of reset_seq.
// A load takes priority over a decrement; decrementing at zero holds zero.
module reset_seq_cnt
  import reset_seq_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/reset_seq.sv
// Staggered per-channel reset sequencer with power-on and retrigger sequences.
// Optional saturating completed-sequence counter when RESET_SEQ_COUNT_EN is defined.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int HOLD_CYC    = DEF_HOLD_CYC,
  parameter int STAGGER_CYC = DEF_STAGGER_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trig_req,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              trig_ack,
  output logic [NUM_CH-1:0] rst_out,
  output logic              busy,
  output logic              done,
  output state_e            state_dbg
`ifdef RESET_SEQ_COUNT_EN
  ,
  output logic [15:0]       seq_count
`endif
);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] STAG_LD = (STAGGER_CYC == 0) ? '0 : CNT_W'(STAGGER_CYC - 1);

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] act_q, act_d;
  logic [NUM_CH-1:0] rst_q, rst_d;
  logic              ack_q, ack_d;
  logic              done_q, done_d;
  logic              loaded_q, loaded_d;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]  cnt_val;
  logic [NUM_CH-1:0] low_bit, rel_mask;

  reset_seq_cnt #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign low_bit  = act_q & (~act_q + NUM_CH'(1));
  assign rel_mask = (STAGGER_CYC == 0) ? act_q : low_bit;

  always_comb begin
    state_d  = state_q;
    act_d    = act_q;
    rst_d    = rst_q;
    ack_d    = 1'b0;
    done_d   = 1'b0;
    loaded_d = loaded_q;
    cnt_load = 1'b0;
    cnt_val  = HOLD_LD;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trig_req) begin
          ack_d = 1'b1;
          if (ch_mask != '0) begin
            act_d    = ch_mask;
            rst_d    = rst_q | ch_mask;
            state_d  = ST_ASSERT;
            cnt_load = 1'b1;
            loaded_d = 1'b1;
          end
        end
      end
      ST_ASSERT: begin
        // Coming out of reset the hold count has not been loaded yet; the
        // first edge after release loads it so power-on holds as long as a retrigger.
        if (!loaded_q) begin
          cnt_load = 1'b1;
          loaded_d = 1'b1;
        end else if (cnt_zero) begin
          rst_d    = rst_q & ~rel_mask;
          act_d    = act_q & ~rel_mask;
          state_d  = ST_RELEASE;
          cnt_load = 1'b1;
          cnt_val  = STAG_LD;
          loaded_d = 1'b0;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (act_q == '0) begin
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = '0;
        end else if (cnt_zero) begin
          rst_d    = rst_q & ~rel_mask;
          act_d    = act_q & ~rel_mask;
          cnt_load = 1'b1;
          cnt_val  = STAG_LD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_ASSERT;
      act_q    <= '1;
      rst_q    <= '1;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      act_q    <= act_d;
      rst_q    <= rst_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      loaded_q <= loaded_d;
    end
  end

  assign trig_ack  = ack_q;
  assign rst_out   = rst_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign state_dbg = state_q;

`ifdef RESET_SEQ_COUNT_EN
  logic [15:0] seq_q, seq_d;

  always_comb begin
    seq_d = seq_q;
    if (done_d && (seq_q != 16'hFFFF)) seq_d = seq_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) seq_q <= '0;
    else        seq_q <= seq_d;
  end

  assign seq_count = seq_q;
`endif
endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq (NUM_CH=4, HOLD_CYC=8, STAGGER_CYC=2); also
// checks seq_count when built with RESET_SEQ_COUNT_EN.
module tb_reset_seq;
  import reset_seq_pkg::*;

  typedef struct {
    logic       req;
    logic [3:0] mask;
    logic [6:0] exp;   // {trig_ack, busy, done, rst_out[3:0]}
  } vec_t;

  logic   clk;
  logic   reset;
  state_e state_dbg;
  int     n_tests = 0;
  int     n_fail  = 0;
  vec_t   vec[32];

  reset_seq_if #(.NUM_CH(4)) bus ();

`ifdef RESET_SEQ_COUNT_EN
  logic [15:0] seq_count;
`endif

  reset_seq #(.NUM_CH(4), .HOLD_CYC(8), .STAGGER_CYC(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .trig_req  (bus.trig_req),
    .ch_mask   (bus.ch_mask),
    .trig_ack  (bus.trig_ack),
    .rst_out   (bus.rst_out),
    .busy      (bus.busy),
    .done      (bus.done),
    .state_dbg (state_dbg)
`ifdef RESET_SEQ_COUNT_EN
    ,
    .seq_count (seq_count)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] pk(input logic ack, input logic bsy,
                                    input logic dn, input logic [3:0] r);
    return {ack, bsy, dn, r};
  endfunction

  task automatic check(input string nm, input logic [6:0] got, input logic [6:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got ack,busy,done,rst=%b required %b", nm, got, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {bus.trig_ack, bus.busy, bus.done, bus.rst_out};
  endfunction

  // Driver: apply inputs, take one edge, sample 1 time unit later
  task automatic cyc(input string nm, input logic req, input logic [3:0] mask,
                     input logic [6:0] exp);
    bus.trig_req = req;
    bus.ch_mask  = mask;
    @(posedge clk);
    #1;
    check(nm, outs(), exp);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      cyc($sformatf("vec%0d", i), vec[i].req, vec[i].mask, vec[i].exp);
    end
  endtask

  initial begin
    // Power-on: edges 0..16 after reset release
    for (int e = 0; e <= 16; e++) begin
      vec[e].req  = 1'b0;
      vec[e].mask = 4'b0000;
      vec[e].exp  = pk(1'b0, (e < 15), (e == 15),
                       (e < 8)  ? 4'b1111 :
                       (e < 10) ? 4'b1110 :
                       (e < 12) ? 4'b1100 :
                       (e < 14) ? 4'b1000 : 4'b0000);
    end
    // Retrigger with mask 1010, accepted at k=0
    for (int k = 0; k <= 12; k++) begin
      vec[17+k].req  = (k == 0);
      vec[17+k].mask = (k == 0) ? 4'b1010 : 4'b0000;
      vec[17+k].exp  = pk((k == 0), (k < 11), (k == 11),
                          (k < 8)  ? 4'b1010 :
                          (k < 10) ? 4'b1000 : 4'b0000);
    end
    // Empty-mask request: acked, stays idle
    vec[30].req = 1'b1; vec[30].mask = 4'b0000; vec[30].exp = pk(1'b1, 1'b0, 1'b0, 4'b0000);
    vec[31].req = 1'b0; vec[31].mask = 4'b0000; vec[31].exp = pk(1'b0, 1'b0, 1'b0, 4'b0000);

    bus.trig_req = 1'b0;
    bus.ch_mask  = 4'b0000;
    reset        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", outs(), pk(1'b0, 1'b1, 1'b0, 4'b1111));
    n_tests++;
    if (state_dbg !== ST_ASSERT) begin
      n_fail++;
      $display("FAIL reset_fsm: got state %0d required %0d", state_dbg, ST_ASSERT);
    end
`ifdef RESET_SEQ_COUNT_EN
    n_tests++;
    if (seq_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got seq_count %0d required 0", seq_count);
    end
`endif
    reset = 1'b1;

    run_vecs(0, 31);

    // Request held through the end of a sequence is accepted on the first idle cycle
    cyc("hq_acc", 1'b1, 4'b0001, pk(1'b1, 1'b1, 1'b0, 4'b0001));
    for (int k = 1; k <= 7; k++) begin
      cyc($sformatf("hq_hold%0d", k), 1'b1, 4'b0100, pk(1'b0, 1'b1, 1'b0, 4'b0001));
    end
    cyc("hq_clr",  1'b1, 4'b0100, pk(1'b0, 1'b1, 1'b0, 4'b0000));
    cyc("hq_done", 1'b1, 4'b0100, pk(1'b0, 1'b0, 1'b1, 4'b0000));
`ifdef RESET_SEQ_COUNT_EN
    n_tests++;
    if (seq_count !== 16'd3) begin
      n_fail++;
      $display("FAIL cnt_three: got seq_count %0d required 3", seq_count);
    end
`endif
    cyc("hq_acc2", 1'b1, 4'b0100, pk(1'b1, 1'b1, 1'b0, 4'b0100));
    cyc("hq_hold", 1'b0, 4'b0000, pk(1'b0, 1'b1, 1'b0, 4'b0100));
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
        @(posedge clk);
        #1;
        if (bus.done) seen = 1'b1;
      end
      n_tests++;
      if (!seen) begin
        n_fail++;
        $display("FAIL hq_wait: got no done within 40 cycles required done pulse");
      end
      check("hq_end", outs(), pk(1'b0, 1'b0, 1'b1, 4'b0000));
    end

    // Reset pulsed low at edge 11 of a power-on sequence
    #1 reset = 1'b0;
    #1 reset = 1'b1;
    run_vecs(0, 11);
    #1 reset = 1'b0;
    #1;
    check("async_rst", outs(), pk(1'b0, 1'b1, 1'b0, 4'b1111));
`ifdef RESET_SEQ_COUNT_EN
    n_tests++;
    if (seq_count !== 16'd0) begin
      n_fail++;
      $display("FAIL cnt_reset: got seq_count %0d required 0", seq_count);
    end
`endif
    #1 reset = 1'b1;
    run_vecs(0, 16);
`ifdef RESET_SEQ_COUNT_EN
    n_tests++;
    if (seq_count !== 16'd1) begin
      n_fail++;
      $display("FAIL cnt_por: got seq_count %0d required 1", seq_count);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/reset_seq.md
RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of reset channels (1..16).
REQ-002 SHALL have parameter HOLD_CYC, default 8, cycles all selected channels stay asserted (1..255).
REQ-003 SHALL have parameter STAGGER_CYC, default 2, cycles between successive channel releases (0..255).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port trig_req  input  1  level retrigger request, held until trig_ack.
REQ-007 SHALL have port ch_mask  input  NUM_CH  channels to retrigger, sampled on acceptance.
REQ-008 SHALL have port trig_ack  output  1  one-cycle pulse, request accepted.
REQ-009 SHALL have port rst_out  output  NUM_CH  active-high per-channel resets, registered.
REQ-010 SHALL have port busy  output  1  high in any state except IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse when a sequence completes.

Function
REQ-012 SHALL implement FSM states IDLE, ASSERT, RELEASE.
- IDLE: trig_req=1, mask nonzero -> ASSERT.
- ASSERT: after HOLD_CYC cycles -> RELEASE.
- RELEASE: after the last selected channel is released -> IDLE.
REQ-013 SHALL, in IDLE with trig_req=1, capture ch_mask into an active mask, pulse trig_ack, and set the masked rst_out bits on the same edge.
REQ-014 SHALL keep active channels asserted for exactly HOLD_CYC cycles, then clear the lowest-index active bit.
REQ-015 SHALL clear each further active bit, in ascending index, STAGGER_CYC cycles after the previous one; inactive indices are skipped and consume no cycles.
REQ-016 SHALL, with STAGGER_CYC=0, clear all active bits on the same edge.
REQ-017 SHALL leave rst_out bits outside the active mask unchanged during a retrigger.
REQ-018 SHALL pulse done and enter IDLE on the edge after the last active bit clears.
REQ-019 SHALL ignore trig_req outside IDLE; a request still held is accepted on the first IDLE cycle.
REQ-020 SHALL treat trig_req with ch_mask=0 as accepted: trig_ack pulses, FSM stays IDLE, no done pulse.
REQ-021 SHALL use a counter of $clog2(256) bits that never wraps; it is reloaded on every state or channel step.

Reset
REQ-022 SHALL, while reset=0, force rst_out to all-ones, busy=1, trig_ack=0, done=0, active mask all-ones, counter 0, and state ASSERT.
REQ-023 SHALL, after reset deassertion, run the power-on sequence of REQ-014..REQ-018 over all channels.
REQ-024 SHALL abort any in-flight sequence when reset is asserted mid-operation, with no done pulse.

Configuration
REQ-025 SHALL, when RESET_SEQ_COUNT_EN is defined, add output seq_count (16 bits).
- Reset value 0.
- Increments on each done pulse.
- Saturates at 16'hFFFF.
REQ-026 SHALL, without RESET_SEQ_COUNT_EN, omit the seq_count port and counter entirely.

Structure
REQ-027 SHALL place the state enum typedef, the default parameter constants, and the counter width constant in package reset_seq_pkg.
REQ-028 SHALL implement the hold/stagger down-counter as sub-module reset_seq_cnt (load, decrement, zero flag).

Verification (NUM_CH=4, HOLD_CYC=8, STAGGER_CYC=2)
REQ-029 SHALL check power-on: reset released at edge 0.
- rst_out=4'b1111 through edge 7.
- Bits 0/1/2/3 clear at edges 8/10/12/14.
- done pulses and busy falls at edge 15.
REQ-030 SHALL check retrigger with ch_mask=4'b1010 in IDLE.
- trig_ack pulses and rst_out=4'b1010 on the same edge.
- Bit1 clears 8 cycles later; bit3 clears 2 cycles after that.
- Bits 0 and 2 stay 0 throughout.
REQ-031 SHALL check trig_req held high during RELEASE: it is not acked until IDLE, then is accepted on the first IDLE cycle.
REQ-032 SHALL check trig_req with ch_mask=0: trig_ack pulses, rst_out stays 0, busy stays 0, no done pulse.
REQ-033 SHALL check reset pulsed low at edge 11 of a sequence: rst_out=4'b1111 immediately (asynchronous), then the full power-on sequence restarts.
REQ-034 SHALL check, with RESET_SEQ_COUNT_EN defined, seq_count=3 after power-on plus two retriggers, and 0 after reset.
